// File: rtl/mem_bus_arbiter.sv
// Two-requester (IF / MEM) arbiter and strobe sequencer for the ram2 async SRAM.
// Define ARB_RR_EN for round-robin tie-breaking; default is fixed MEM priority.
module mem_bus_arbiter #(
   parameter int RD_CYCLES = 2,
   parameter int WR_SETUP  = 1,
   parameter int WR_PULSE  = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_ack,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   output logic        mem_ack,
   output logic        busy,
   output logic        ram2EN,
   output logic        ram2OE,
   output logic        ram2WE,
   output logic [17:0] ram2Addr,
   inout  wire  [15:0] ram2Data
);

   typedef enum logic [2:0] {
      IDLE, READ, WSETUP, WPULSE, WHOLD, DONE
   } state_t;

   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n;
   logic        grant, pick_mem, sample;
   logic        owner_mem;
   logic        drv;
   logic [15:0] wdata_q;
   logic        en_d, oe_d, we_d, drv_d, busy_d;
   logic        if_ack_d, mem_ack_d;

   assign grant  = (state == IDLE) && (if_req || mem_req);
   assign sample = (state == READ) && (cnt == 3'd0);

`ifdef ARB_RR_EN
   logic last_mem;

   // On a tie the requester that was not granted last wins
   always_comb begin
      pick_mem = mem_req && (!if_req || !last_mem);
   end

   always_ff @(posedge CLK) begin
      if (!RST)
         last_mem <= 1'b0;
      else if (grant)
         last_mem <= pick_mem;
   end
`else
   always_comb begin
      pick_mem = mem_req;
   end
`endif

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (grant) begin
               if (pick_mem && mem_we) begin
                  state_n = WSETUP;
                  cnt_n   = 3'(WR_SETUP - 1);
               end else begin
                  state_n = READ;
                  cnt_n   = 3'(RD_CYCLES - 1);
               end
            end
         end
         READ: begin
            if (cnt == 3'd0)
               state_n = DONE;
            else
               cnt_n = cnt - 3'd1;
         end
         WSETUP: begin
            if (cnt == 3'd0) begin
               state_n = WPULSE;
               cnt_n   = 3'(WR_PULSE - 1);
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         WPULSE: begin
            if (cnt == 3'd0) begin
               state_n = WHOLD;
               cnt_n   = 3'd0;
            end else begin
               cnt_n = cnt - 3'd1;
            end
         end
         WHOLD:   state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Pin values are decoded from the next state so every pin is a flop
   always_comb begin
      en_d      = 1'b1;
      oe_d      = 1'b1;
      we_d      = 1'b1;
      drv_d     = 1'b0;
      if_ack_d  = 1'b0;
      mem_ack_d = 1'b0;
      case (state_n)
         READ: begin
            en_d = 1'b0;
            oe_d = 1'b0;
         end
         WSETUP, WHOLD: begin
            en_d  = 1'b0;
            drv_d = 1'b1;
         end
         WPULSE: begin
            en_d  = 1'b0;
            we_d  = 1'b0;
            drv_d = 1'b1;
         end
         DONE: begin
            if (owner_mem)
               mem_ack_d = 1'b1;
            else
               if_ack_d = 1'b1;
         end
         default: ;
      endcase
      busy_d = (state_n != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         ram2EN    <= 1'b1;
         ram2OE    <= 1'b1;
         ram2WE    <= 1'b1;
         ram2Addr  <= 18'd0;
         drv       <= 1'b0;
         wdata_q   <= 16'd0;
         owner_mem <= 1'b0;
         busy      <= 1'b0;
         if_ack    <= 1'b0;
         mem_ack   <= 1'b0;
         if_rdata  <= 16'd0;
         mem_rdata <= 16'd0;
      end else begin
         ram2EN  <= en_d;
         ram2OE  <= oe_d;
         ram2WE  <= we_d;
         drv     <= drv_d;
         busy    <= busy_d;
         if_ack  <= if_ack_d;
         mem_ack <= mem_ack_d;
         if (grant) begin
            owner_mem <= pick_mem;
            ram2Addr  <= {2'b00, pick_mem ? mem_addr : if_addr};
            wdata_q   <= mem_wdata;
         end
         if (sample) begin
            if (owner_mem)
               mem_rdata <= ram2Data;
            else
               if_rdata <= ram2Data;
         end
      end
   end

   assign ram2Data = drv ? wdata_q : 16'hzzzz;

endmodule
